// File: rtl/button_pkg.sv
// Shared types for the button press decoder: event codes, FSM states, counter width.
// S_WAIT_SECOND exists only when BUTTON_DOUBLE_CLICK_EN is defined.
package button_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CODE_W = 2;

  typedef enum logic [CODE_W-1:0] {
    EVT_SHORT  = 2'd0,
    EVT_LONG   = 2'd1,
    EVT_DOUBLE = 2'd2
  } evt_code_t;

  typedef enum logic [1:0] {
    S_WAIT_RELEASE = 2'd0,
    S_IDLE         = 2'd1,
    S_PRESSED      = 2'd2
`ifdef BUTTON_DOUBLE_CLICK_EN
    ,
    S_WAIT_SECOND  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/button_event_slot.sv
// One-entry event holding register: loads when empty or being drained,
// otherwise drops the new event and pulses event_dropped.
module button_event_slot
  import button_pkg::*;
(
  input  logic              clk,
  input  logic              areset,
  input  logic              emit_c,
  input  evt_code_t         emit_code_c,
  input  logic              event_ready,
  output logic              event_valid,
  output logic [CODE_W-1:0] event_code,
  output logic              event_dropped
);

  evt_code_t code_q;

  assign event_code = code_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      event_valid   <= 1'b0;
      code_q        <= EVT_SHORT;
      event_dropped <= 1'b0;
    end else begin
      event_dropped <= 1'b0;
      if (emit_c) begin
        if (!event_valid || event_ready) begin
          event_valid <= 1'b1;
          code_q      <= emit_code_c;
        end else begin
          event_dropped <= 1'b1;
        end
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_press_decoder.sv
// Classifies debounced button presses into SHORT / LONG / DOUBLE events.
// DOUBLE detection and S_WAIT_SECOND are built only with BUTTON_DOUBLE_CLICK_EN.
module button_press_decoder
  import button_pkg::*;
(
  input  logic              clk,
  input  logic              areset,
  input  logic [CNT_W-1:0]  long_press_count,
  input  logic [CNT_W-1:0]  double_click_window,
  input  logic              btn_level,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [CODE_W-1:0] event_code,
  output logic              event_dropped
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit_c;
  evt_code_t        emit_code_c;

`ifndef BUTTON_DOUBLE_CLICK_EN
  logic unused_window;
  assign unused_window = ^double_click_window;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_WAIT_RELEASE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    emit_c      = 1'b0;
    emit_code_c = EVT_SHORT;
    case (state_q)
      S_WAIT_RELEASE: begin
        if (!btn_level) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (btn_level) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (btn_level) begin
          if ((long_press_count != '0) && (cnt_q == long_press_count - CNT_W'(1))) begin
            emit_c      = 1'b1;
            emit_code_c = EVT_LONG;
            state_d     = S_WAIT_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
`ifdef BUTTON_DOUBLE_CLICK_EN
          if (double_click_window != '0) begin
            state_d = S_WAIT_SECOND;
          end else begin
            emit_c  = 1'b1;
            state_d = S_IDLE;
          end
`else
          emit_c  = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef BUTTON_DOUBLE_CLICK_EN
      // A second press wins over window expiry in the same cycle.
      S_WAIT_SECOND: begin
        if (btn_level) begin
          emit_c      = 1'b1;
          emit_code_c = EVT_DOUBLE;
          state_d     = S_WAIT_RELEASE;
        end else if (cnt_q == double_click_window - CNT_W'(1)) begin
          emit_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_WAIT_RELEASE;
    endcase
    // Counter restarts from zero on every state entry.
    if (state_d != state_q) cnt_d = '0;
  end

  button_event_slot u_slot (
    .clk           (clk),
    .areset        (areset),
    .emit_c        (emit_c),
    .emit_code_c   (emit_code_c),
    .event_ready   (event_ready),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_dropped (event_dropped)
  );

endmodule
